// File: rtl/cpu_pkg.sv
// Shared widths, IR field positions, branch-condition codes and the debug view
// of the single-bus datapath.
package cpu_pkg;
    localparam int WORD_W    = 32;
    localparam int MEM_WORDS = 512;
    localparam int ADDR_W    = 9;
    localparam int NUM_REGS  = 16;
    localparam int FIELD_W   = 4;
    localparam int RA_LSB    = 23;
    localparam int RB_LSB    = 19;
    localparam int RC_LSB    = 15;
    localparam int C_MSB     = 18;
    localparam int COND_LSB  = 19;

    typedef enum logic [1:0] {
        BR_ZR = 2'd0,
        BR_NZ = 2'd1,
        BR_PL = 2'd2,
        BR_MI = 2'd3
    } br_cond_e;

    typedef struct packed {
        logic [WORD_W-1:0]   pc;
        logic [WORD_W-1:0]   ir;
        logic [WORD_W-1:0]   mar;
        logic [WORD_W-1:0]   mdr;
        logic [WORD_W-1:0]   y;
        logic [2*WORD_W-1:0] z;
        logic [WORD_W-1:0]   hi;
        logic [WORD_W-1:0]   lo;
        logic [WORD_W-1:0]   bus;
    } cpu_dbg_t;

    function automatic logic branch_taken(br_cond_e cond, logic [WORD_W-1:0] val);
        logic taken;
        case (cond)
            BR_ZR:   taken = (val == '0);
            BR_NZ:   taken = (val != '0);
            BR_PL:   taken = ~val[WORD_W-1];
            default: taken = val[WORD_W-1];
        endcase
        return taken;
    endfunction
endpackage

// File: rtl/cpu_if.sv
// Control strobes and external ports of the datapath. No handshakes: every
// strobe held high during a cycle acts on the next rising clock edge.
interface cpu_if;
    import cpu_pkg::*;

    logic                IncPC;
    logic [NUM_REGS-1:0] Rnout;
    logic [NUM_REGS-1:0] Rnin;
    logic                Gra, Grb, Grc;
    logic                Rin, Rout, BAout;
    logic                MARin, MDRout, MDRin, memRead, ramEnable;
    logic                PCin, PCout;
    logic                ADD, Zin, Zhighout, Zlowout;
    logic                HIin, LOin, HIout, LOout;
    logic                Yin, IRin, Cout;
    logic [WORD_W-1:0]   InPortData;
    logic                InPort_Out;
    logic [WORD_W-1:0]   OutPortData;
    logic                OutPort_In;
    logic                CONin;
    logic                CON;
    cpu_dbg_t            dbg;

    modport master (
        output IncPC, Rnout, Rnin, Gra, Grb, Grc, Rin, Rout, BAout,
        output MARin, MDRout, MDRin, memRead, ramEnable, PCin, PCout,
        output ADD, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout,
        output Yin, IRin, Cout, InPortData, InPort_Out, OutPort_In, CONin,
        input  OutPortData, CON, dbg
    );

    modport slave (
        input  IncPC, Rnout, Rnin, Gra, Grb, Grc, Rin, Rout, BAout,
        input  MARin, MDRout, MDRin, memRead, ramEnable, PCin, PCout,
        input  ADD, Zin, Zhighout, Zlowout, HIin, LOin, HIout, LOout,
        input  Yin, IRin, Cout, InPortData, InPort_Out, OutPort_In, CONin,
        output OutPortData, CON, dbg
    );
endinterface

// File: rtl/cpu_reg_file.sv
// Sixteen general registers with IR-field select/encode. Lowest-numbered
// enabled register wins the bus; R0 driven through BAout alone reads as zero.
module cpu_reg_file
    import cpu_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic [WORD_W-1:0]   bus_val,
    input  logic [FIELD_W-1:0]  ra,
    input  logic [FIELD_W-1:0]  rb,
    input  logic [FIELD_W-1:0]  rc,
    input  logic [NUM_REGS-1:0] rn_in,
    input  logic [NUM_REGS-1:0] rn_out,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                ba_out,
    output logic                drv_en,
    output logic [WORD_W-1:0]   drv_val
);
    logic [NUM_REGS-1:0][WORD_W-1:0] regs_q, regs_d;
    logic [FIELD_W-1:0]  sel_field;
    logic                sel_valid;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] load;
    logic [NUM_REGS-1:0] out_en;
    logic                r0_reads_zero;

    always_comb begin
        sel_field = '0;
        sel_valid = 1'b0;
        if (gra) begin
            sel_field = ra;
            sel_valid = 1'b1;
        end else if (grb) begin
            sel_field = rb;
            sel_valid = 1'b1;
        end else if (grc) begin
            sel_field = rc;
            sel_valid = 1'b1;
        end
        dec    = sel_valid ? (NUM_REGS'(1) << sel_field) : '0;
        load   = rn_in | (rin ? dec : '0);
        out_en = rn_out | ((rout | ba_out) ? dec : '0);
        // BAout gives base-address semantics only when nothing else asks for the real R0.
        r0_reads_zero = ba_out & dec[0] & ~rn_out[0] & ~rout;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = load[i] ? bus_val : regs_q[i];
        end
    end

    always_comb begin
        drv_en  = 1'b0;
        drv_val = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (out_en[i]) begin
                drv_en  = 1'b1;
                drv_val = (i == 0 && r0_reads_zero) ? '0 : regs_q[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end
endmodule

// File: rtl/cpu.sv
// Single-bus 32-bit datapath top: bus mux, special registers, adder, RAM and
// branch-condition flop, all sequenced by external one-hot strobes.
module cpu
    import cpu_pkg::*;
(
    input  logic  clock,
    input  logic  clear,
    cpu_if.slave  ctl
);
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [WORD_W-1:0]   mar_q, mar_d;
    logic [WORD_W-1:0]   mdr_q, mdr_d;
    logic [WORD_W-1:0]   y_q, y_d;
    logic [2*WORD_W-1:0] z_q, z_d;
    logic [WORD_W-1:0]   hi_q, hi_d;
    logic [WORD_W-1:0]   lo_q, lo_d;
    logic [WORD_W-1:0]   out_port_q, out_port_d;
    logic                con_q, con_d;
    logic [WORD_W-1:0]   ram_q [MEM_WORDS];

    logic [WORD_W-1:0] bus_val;
    logic [WORD_W-1:0] c_val;
    logic [WORD_W-1:0] alu_res;
    logic [WORD_W-1:0] ram_rd;
    logic              rf_drv_en;
    logic [WORD_W-1:0] rf_drv_val;

    cpu_reg_file u_reg_file (
        .clock   (clock),
        .clear   (clear),
        .bus_val (bus_val),
        .ra      (ir_q[RA_LSB +: FIELD_W]),
        .rb      (ir_q[RB_LSB +: FIELD_W]),
        .rc      (ir_q[RC_LSB +: FIELD_W]),
        .rn_in   (ctl.Rnin),
        .rn_out  (ctl.Rnout),
        .gra     (ctl.Gra),
        .grb     (ctl.Grb),
        .grc     (ctl.Grc),
        .rin     (ctl.Rin),
        .rout    (ctl.Rout),
        .ba_out  (ctl.BAout),
        .drv_en  (rf_drv_en),
        .drv_val (rf_drv_val)
    );

    assign ram_rd = ram_q[mar_q[ADDR_W-1:0]];

    always_comb begin
        c_val = {{(WORD_W-C_MSB-1){ir_q[C_MSB]}}, ir_q[C_MSB:0]};
        if (rf_drv_en)           bus_val = rf_drv_val;
        else if (ctl.HIout)      bus_val = hi_q;
        else if (ctl.LOout)      bus_val = lo_q;
        else if (ctl.Zhighout)   bus_val = z_q[2*WORD_W-1:WORD_W];
        else if (ctl.Zlowout)    bus_val = z_q[WORD_W-1:0];
        else if (ctl.PCout)      bus_val = pc_q;
        else if (ctl.MDRout)     bus_val = mdr_q;
        else if (ctl.InPort_Out) bus_val = ctl.InPortData;
        else if (ctl.Cout)       bus_val = c_val;
        else                     bus_val = '0;
    end

    always_comb begin
        pc_d = pc_q;
        if (ctl.PCin)       pc_d = bus_val;
        else if (ctl.IncPC) pc_d = pc_q + WORD_W'(1);
        ir_d       = ctl.IRin       ? bus_val : ir_q;
        mar_d      = ctl.MARin      ? bus_val : mar_q;
        mdr_d      = ctl.MDRin      ? (ctl.memRead ? ram_rd : bus_val) : mdr_q;
        y_d        = ctl.Yin        ? bus_val : y_q;
        hi_d       = ctl.HIin       ? bus_val : hi_q;
        lo_d       = ctl.LOin       ? bus_val : lo_q;
        out_port_d = ctl.OutPort_In ? bus_val : out_port_q;
        alu_res    = ctl.ADD ? (y_q + bus_val) : bus_val;
        z_d        = ctl.Zin ? {{WORD_W{1'b0}}, alu_res} : z_q;
        con_d      = ctl.CONin
                   ? branch_taken(br_cond_e'(ir_q[COND_LSB +: 2]), bus_val)
                   : con_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q       <= '0;
            ir_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            y_q        <= '0;
            z_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            out_port_q <= '0;
            con_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            y_q        <= y_d;
            z_q        <= z_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            out_port_q <= out_port_d;
            con_q      <= con_d;
        end
    end

    // RAM keeps its contents through clear; a write during clear is suppressed.
    always_ff @(posedge clock) begin
        if (!clear && ctl.ramEnable) begin
            ram_q[mar_q[ADDR_W-1:0]] <= mdr_q;
        end
    end

    assign ctl.OutPortData = out_port_q;
    assign ctl.CON         = con_q;
    assign ctl.dbg         = cpu_dbg_t'{pc: pc_q, ir: ir_q, mar: mar_q, mdr: mdr_q,
                                        y: y_q, z: z_q, hi: hi_q, lo: lo_q, bus: bus_val};
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for the cpu datapath: directed instruction sequences and a
// randomized register/memory transfer mix against a behavioural model.
module tb_cpu;
    import cpu_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    cpu_if cif ();

    cpu dut (
        .clock (clock),
        .clear (clear),
        .ctl   (cif)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_gpr [16];
    logic [31:0] m_mem [int];
    logic [31:0] m_pc;

    function automatic logic ref_con(logic [1:0] cond, logic [31:0] v);
        case (cond)
            2'd0:    return v == 32'd0;
            2'd1:    return v != 32'd0;
            2'd2:    return $signed(v) >= 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    function automatic logic [31:0] sext19(logic [31:0] v);
        return v[18] ? ((v & 32'h0007_FFFF) | 32'hFFF8_0000) : (v & 32'h0007_FFFF);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        cif.IncPC = 0; cif.Rnout = '0; cif.Rnin = '0;
        cif.Gra = 0; cif.Grb = 0; cif.Grc = 0; cif.Rin = 0; cif.Rout = 0; cif.BAout = 0;
        cif.MARin = 0; cif.MDRout = 0; cif.MDRin = 0; cif.memRead = 0; cif.ramEnable = 0;
        cif.PCin = 0; cif.PCout = 0; cif.ADD = 0; cif.Zin = 0; cif.Zhighout = 0; cif.Zlowout = 0;
        cif.HIin = 0; cif.LOin = 0; cif.HIout = 0; cif.LOout = 0;
        cif.Yin = 0; cif.IRin = 0; cif.Cout = 0;
        cif.InPort_Out = 0; cif.OutPort_In = 0; cif.CONin = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic put_reg(int r, logic [31:0] v);
        cif.InPortData = v; cif.InPort_Out = 1; cif.Rnin[r] = 1'b1;
        cycle();
        m_gpr[r] = v;
    endtask

    task automatic get_reg(int r);
        cif.Rnout[r] = 1'b1; cif.OutPort_In = 1;
        cycle();
    endtask

    task automatic load_ir(logic [31:0] v);
        cif.InPortData = v; cif.InPort_Out = 1; cif.IRin = 1;
        cycle();
    endtask

    task automatic load_mar(logic [31:0] v);
        cif.InPortData = v; cif.InPort_Out = 1; cif.MARin = 1;
        cycle();
    endtask

    task automatic load_mdr(logic [31:0] v);
        cif.InPortData = v; cif.InPort_Out = 1; cif.MDRin = 1;
        cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int r = 0; r < 16; r++) put_reg(r, $urandom | 32'h1);
        load_ir(32'hBA98_000E);
        load_mar(32'h1FF);
        cif.IncPC = 1; cycle();
        // clear wins over every strobe raised in the same cycle
        clear = 1'b1;
        cif.InPortData = 32'hFFFF_FFFF; cif.InPort_Out = 1; cif.Rnin = '1;
        cif.IncPC = 1; cif.CONin = 1; cif.OutPort_In = 1; cif.Zin = 1; cif.Yin = 1;
        cycle();
        clear = 1'b0;
        m_pc = 0;
        for (int r = 0; r < 16; r++) m_gpr[r] = 32'd0;
        checks++; if (cif.dbg.pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", cif.dbg.pc); end
        checks++; if (cif.CON !== 1'b0) begin errors++; $display("FAIL reset_con got %b want 0", cif.CON); end
        checks++; if (cif.OutPortData !== 32'd0) begin errors++; $display("FAIL reset_outport got %h want 0", cif.OutPortData); end
        checks++; if (cif.dbg.ir !== 32'd0 || cif.dbg.mar !== 32'd0 || cif.dbg.mdr !== 32'd0 || cif.dbg.y !== 32'd0) begin
            errors++; $display("FAIL reset_ir_mar_mdr_y got %h %h %h %h want 0", cif.dbg.ir, cif.dbg.mar, cif.dbg.mdr, cif.dbg.y);
        end
        checks++; if (cif.dbg.z !== 64'd0 || cif.dbg.hi !== 32'd0 || cif.dbg.lo !== 32'd0) begin
            errors++; $display("FAIL reset_z_hi_lo got %h %h %h want 0", cif.dbg.z, cif.dbg.hi, cif.dbg.lo);
        end
        for (int r = 0; r < 16; r++) begin
            get_reg(r);
            checks++; if (cif.OutPortData !== 32'd0) begin errors++; $display("FAIL reset_r%0d got %h want 0", r, cif.OutPortData); end
        end
    endtask

    task automatic branch_step(logic [31:0] ir);
        logic        ec;
        logic [31:0] ez;
        load_ir(ir);
        cif.Gra = 1; cif.Rout = 1; cif.CONin = 1; cycle();
        ec = ref_con(ir[20:19], m_gpr[ir[26:23]]);
        checks++; if (cif.CON !== ec) begin errors++; $display("FAIL branch_con ir=%h got %b want %b", ir, cif.CON, ec); end
        cif.PCout = 1; cif.Yin = 1; cycle();
        cif.Cout = 1; cif.ADD = 1; cif.Zin = 1; cycle();
        ez = m_pc + sext19(ir);
        checks++; if (cif.dbg.z !== {32'd0, ez}) begin errors++; $display("FAIL branch_z ir=%h got %h want %h", ir, cif.dbg.z, {32'd0, ez}); end
        if (cif.CON) begin
            cif.Zlowout = 1; cif.PCin = 1; cycle();
        end
        if (ec) m_pc = ez;
        checks++; if (cif.dbg.pc !== m_pc) begin errors++; $display("FAIL branch_pc ir=%h got %h want %h", ir, cif.dbg.pc, m_pc); end
    endtask

    task automatic inc_pc_check();
        cif.IncPC = 1; cycle();
        m_pc = m_pc + 1;
        checks++; if (cif.dbg.pc !== m_pc) begin errors++; $display("FAIL incpc got %h want %h", cif.dbg.pc, m_pc); end
    endtask

    task automatic test_branch();
        put_reg(5, 32'hFFFF_FFF6);
        cif.PCout = 1; cif.MARin = 1; cif.IncPC = 1;
        #1;
        checks++; if (cif.dbg.bus !== m_pc) begin errors++; $display("FAIL pcout_incpc_bus got %h want %h", cif.dbg.bus, m_pc); end
        cycle();
        m_pc = m_pc + 1;
        checks++; if (cif.dbg.mar !== 32'd0 || cif.dbg.pc !== m_pc) begin
            errors++; $display("FAIL fetch_mar_pc got %h %h want 0 %h", cif.dbg.mar, cif.dbg.pc, m_pc);
        end
        branch_step(32'hBA80_000E); inc_pc_check();
        branch_step(32'hBA88_000E); inc_pc_check();
        branch_step(32'hBA90_000E); inc_pc_check();
        branch_step(32'hBA98_000E);
        checks++; if (cif.dbg.pc !== 32'd32) begin errors++; $display("FAIL brmi_final_pc got %h want 20", cif.dbg.pc); end
    endtask

    task automatic test_memory();
        load_mar(32'd5);
        load_mdr(32'h0000_1234);
        cif.ramEnable = 1; cycle();
        m_mem[5] = 32'h0000_1234;
        load_mdr(32'hAAAA_5555);
        cif.MDRin = 1; cif.memRead = 1; cycle();
        checks++; if (cif.dbg.mdr !== 32'h0000_1234) begin errors++; $display("FAIL mem_read got %h want 00001234", cif.dbg.mdr); end
        // a read in the same cycle as a write returns the previous word
        load_mar(32'd6);
        load_mdr(32'h0000_0055);
        cif.ramEnable = 1; cycle();
        load_mdr(32'h0000_0099);
        cif.ramEnable = 1; cif.MDRin = 1; cif.memRead = 1; cycle();
        checks++; if (cif.dbg.mdr !== 32'h0000_0055) begin errors++; $display("FAIL mem_rw_same_cycle got %h want 00000055", cif.dbg.mdr); end
        cif.MDRin = 1; cif.memRead = 1; cycle();
        checks++; if (cif.dbg.mdr !== 32'h0000_0099) begin errors++; $display("FAIL mem_after_write got %h want 00000099", cif.dbg.mdr); end
    endtask

    task automatic test_ba_out();
        put_reg(0, 32'hDEAD_BEEF);
        load_ir(32'h0000_0000);
        cif.Grb = 1; cif.BAout = 1; cif.OutPort_In = 1;
        #1;
        checks++; if (cif.dbg.bus !== 32'd0) begin errors++; $display("FAIL baout_r0_bus got %h want 0", cif.dbg.bus); end
        cycle();
        checks++; if (cif.OutPortData !== 32'd0) begin errors++; $display("FAIL baout_outport got %h want 0", cif.OutPortData); end
        cif.Grb = 1; cif.Rout = 1; #1;
        checks++; if (cif.dbg.bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rout_r0_bus got %h want deadbeef", cif.dbg.bus); end
        cycle();
        get_reg(5);
        checks++; if (cif.OutPortData !== m_gpr[5]) begin errors++; $display("FAIL outport_r5 got %h want %h", cif.OutPortData, m_gpr[5]); end
    endtask

    task automatic test_misc();
        logic [31:0] v;
        load_ir(32'h0004_0005);
        cif.Cout = 1; #1;
        checks++; if (cif.dbg.bus !== 32'hFFFC_0005) begin errors++; $display("FAIL c_sign_ext got %h want fffc0005", cif.dbg.bus); end
        cycle();
        #1;
        checks++; if (cif.dbg.bus !== 32'd0) begin errors++; $display("FAIL idle_bus got %h want 0", cif.dbg.bus); end
        cif.InPortData = 32'h0000_0100; cif.InPort_Out = 1; cif.PCin = 1; cif.IncPC = 1; cycle();
        m_pc = 32'h100;
        checks++; if (cif.dbg.pc !== m_pc) begin errors++; $display("FAIL pcin_priority got %h want %h", cif.dbg.pc, m_pc); end
        v = $urandom;
        cif.InPortData = v; cif.InPort_Out = 1; cif.HIin = 1; cycle();
        cif.InPortData = ~v; cif.InPort_Out = 1; cif.LOin = 1; cycle();
        cif.HIout = 1; cif.OutPort_In = 1; cycle();
        checks++; if (cif.OutPortData !== v) begin errors++; $display("FAIL hi_out got %h want %h", cif.OutPortData, v); end
        cif.LOout = 1; cif.OutPort_In = 1; cycle();
        checks++; if (cif.OutPortData !== ~v) begin errors++; $display("FAIL lo_out got %h want %h", cif.OutPortData, ~v); end
        cif.HIout = 1; cif.Zin = 1; cycle();
        cif.Zhighout = 1; cif.OutPort_In = 1; cycle();
        checks++; if (cif.OutPortData !== 32'd0) begin errors++; $display("FAIL zhigh_out got %h want 0", cif.OutPortData); end
    endtask

    task automatic test_clear_keeps_ram();
        load_mar(32'd5);
        load_mdr(32'h0BAD_0BAD);
        clear = 1'b1; cif.ramEnable = 1; cycle();
        clear = 1'b0;
        m_pc = 0;
        for (int r = 0; r < 16; r++) m_gpr[r] = 32'd0;
        // only MAR[8:0] addresses the RAM, so 0x205 aliases word 5
        load_mar(32'h0000_0205);
        cif.MDRin = 1; cif.memRead = 1; cycle();
        checks++; if (cif.dbg.mdr !== m_mem[5]) begin errors++; $display("FAIL ram_after_clear got %h want %h", cif.dbg.mdr, m_mem[5]); end
    endtask

    task automatic test_random();
        int          addr_pool [4] = '{0, 7, 300, 511};
        int          op, a, b, c, addr;
        logic [1:0]  cond;
        for (int r = 0; r < 16; r++) put_reg(r, $urandom);
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 4);
            a = $urandom_range(0, 15); b = $urandom_range(0, 15); c = $urandom_range(0, 15);
            addr = addr_pool[$urandom_range(0, 3)];
            if (op == 3 && !m_mem.exists(addr)) op = 2;
            case (op)
                0: begin
                    put_reg(c, $urandom);
                    get_reg(c);
                    checks++; if (cif.OutPortData !== m_gpr[c]) begin errors++; $display("FAIL rnd_put r%0d got %h want %h", c, cif.OutPortData, m_gpr[c]); end
                end
                1: begin
                    cif.Rnout[a] = 1'b1; cif.Yin = 1; cycle();
                    cif.Rnout[b] = 1'b1; cif.ADD = 1; cif.Zin = 1; cycle();
                    cif.Zlowout = 1; cif.Rnin[c] = 1'b1; cycle();
                    m_gpr[c] = m_gpr[a] + m_gpr[b];
                    get_reg(c);
                    checks++; if (cif.OutPortData !== m_gpr[c]) begin errors++; $display("FAIL rnd_add r%0d got %h want %h", c, cif.OutPortData, m_gpr[c]); end
                end
                2: begin
                    load_mar(addr);
                    cif.Rnout[a] = 1'b1; cif.MDRin = 1; cycle();
                    cif.ramEnable = 1; cycle();
                    m_mem[addr] = m_gpr[a];
                end
                3: begin
                    load_mar(addr);
                    cif.MDRin = 1; cif.memRead = 1; cycle();
                    cif.MDRout = 1; cif.Rnin[c] = 1'b1; cycle();
                    m_gpr[c] = m_mem[addr];
                    get_reg(c);
                    checks++; if (cif.OutPortData !== m_gpr[c]) begin errors++; $display("FAIL rnd_load r%0d addr %0d got %h want %h", c, addr, cif.OutPortData, m_gpr[c]); end
                end
                default: begin
                    cond = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) == 0) put_reg(a, 32'd0);
                    load_ir((32'(a) << 23) | (32'(cond) << 19));
                    cif.Gra = 1; cif.Rout = 1; cif.CONin = 1; cycle();
                    checks++; if (cif.CON !== ref_con(cond, m_gpr[a])) begin
                        errors++; $display("FAIL rnd_con r%0d cond %0d got %b want %b", a, cond, cif.CON, ref_con(cond, m_gpr[a]));
                    end
                end
            endcase
        end
    endtask

    initial begin
        idle();
        cif.InPortData = '0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        test_reset();
        test_branch();
        test_memory();
        test_ba_out();
        test_misc();
        test_clear_keeps_ram();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
